// File: rtl/tt_lut_cell_if.sv
// tt_lut_cell_if: bundle of the configuration port and the input/output
// valid/ready streams of tt_lut_cell.
//   master : drives cfg_start/cfg_ch/cfg_bit_valid/cfg_bit, in_valid/in_data,
//            out_ready; observes cfg_busy/cfg_done, in_ready, out_valid,
//            out_data, ones_cnt.
//   slave  : the cell side (directions reversed).
interface tt_lut_cell_if #(
  parameter int N_IN  = 4,
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
) ();
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    cfg_start;
  logic [CH_W-1:0]         cfg_ch;
  logic                    cfg_bit_valid;
  logic                    cfg_bit;
  logic                    cfg_busy;
  logic                    cfg_done;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN-1:0]         in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH-1:0]         out_data;
  logic [N_CH*CNT_W-1:0]   ones_cnt;

  modport master (
    output cfg_start, cfg_ch, cfg_bit_valid, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_busy, cfg_done, in_ready, out_valid, out_data, ones_cnt
  );

  modport slave (
    input  cfg_start, cfg_ch, cfg_bit_valid, cfg_bit, in_valid, in_data, out_ready,
    output cfg_busy, cfg_done, in_ready, out_valid, out_data, ones_cnt
  );
endinterface

// File: rtl/tt_lut_cell.sv
// tt_lut_cell: programmable multi-channel truth-table evaluation cell.
// Each of N_CH channels holds a 2^N_IN-bit table, reloadable through a serial
// MSB-first config port with atomic commit on the last bit. Input vectors are
// looked up in all tables in parallel behind one registered valid/ready stage,
// and a saturating per-channel count of transferred ones is kept.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : tt_lut_cell_if.slave (config port, input stream, output stream,
//          ones counters)
module tt_lut_cell #(
  parameter int                            N_IN  = 4,
  parameter int                            N_CH  = 2,
  parameter logic [N_CH*(2**N_IN)-1:0]     INIT  = {N_CH{16'hE677}},
  parameter int                            CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  tt_lut_cell_if.slave bus
);
  localparam int T    = 2**N_IN;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [T-1:0]           shadow_q, shadow_d;
  logic [N_IN-1:0]        bcnt_q, bcnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [N_CH*T-1:0]      tbl_q, tbl_d;
  logic                   ov_q, ov_d;
  logic [N_CH-1:0]        od_q, od_d;
  logic [N_CH*CNT_W-1:0]  cnt_q, cnt_d;

  logic                   rdy_s;
  logic                   acc_s;
  logic                   xfer_s;
  logic [T-1:0]           new_tbl_s;

  // Table lookup helper: one channel's table indexed by the input vector.
  function automatic logic lut_bit(input logic [T-1:0] t, input logic [N_IN-1:0] idx);
    return t[idx];
  endfunction

  assign rdy_s  = !busy_q && (!ov_q || bus.out_ready);
  assign acc_s  = bus.in_valid && rdy_s;
  assign xfer_s = ov_q && bus.out_ready;

  // Shadow register after shifting in the current serial bit.
  assign new_tbl_s = {shadow_q[T-2:0], bus.cfg_bit};

  // Config FSM: serial load into the shadow, commit whole table on the last bit.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    bcnt_d   = bcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tbl_d    = tbl_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          state_d  = ST_LOAD;
          ch_d     = bus.cfg_ch;
          shadow_d = {T{1'b0}};
          bcnt_d   = {N_IN{1'b0}};
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.cfg_bit_valid) begin
          shadow_d = new_tbl_s;
          bcnt_d   = bcnt_q + N_IN'(1);
          if (bcnt_q == N_IN'(T-1)) begin
            // Out-of-range channel numbers match no slot: load is discarded.
            for (int c = 0; c < N_CH; c++) begin
              if (c == int'(ch_q)) begin
                tbl_d[c*T +: T] = new_tbl_s;
              end else begin
                tbl_d[c*T +: T] = tbl_q[c*T +: T];
              end
            end
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Evaluation stage: register lookups on accept, hold under backpressure.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    if (acc_s) begin
      for (int c = 0; c < N_CH; c++) begin
        od_d[c] = lut_bit(tbl_q[c*T +: T], bus.in_data);
      end
      ov_d = 1'b1;
    end else if (xfer_s) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
  end

  // Saturating ones counters, stepped on every output transfer.
  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < N_CH; c++) begin
      if (xfer_s && od_q[c] && (cnt_q[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
      end else begin
        cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W];
      end
    end
  end

  // State registers with synchronous reset; a reset mid-load drops the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= {CH_W{1'b0}};
      shadow_q <= {T{1'b0}};
      bcnt_q   <= {N_IN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tbl_q    <= INIT;
      ov_q     <= 1'b0;
      od_q     <= {N_CH{1'b0}};
      cnt_q    <= {(N_CH*CNT_W){1'b0}};
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      bcnt_q   <= bcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tbl_q    <= tbl_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_done  = done_q;
  assign bus.in_ready  = rdy_s;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.ones_cnt  = cnt_q;

endmodule

// File: tb/tb_tt_lut_cell.sv
// tb_tt_lut_cell: bench for tt_lut_cell. dut0 uses the defaults (2 channels,
// 8-bit counters) and is checked every cycle against a behavioural model;
// dut1 (1 channel, 2-bit counters) covers counter saturation and the
// out-of-range channel load.
module tb_tt_lut_cell;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  tt_lut_cell_if #(.N_IN(4), .N_CH(2), .CNT_W(8)) bus0 ();
  tt_lut_cell_if #(.N_IN(4), .N_CH(1), .CNT_W(2)) bus1 ();

  tt_lut_cell #(.N_IN(4), .N_CH(2), .INIT({2{16'hE677}}), .CNT_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tt_lut_cell #(.N_IN(4), .N_CH(1), .INIT(16'hE677), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of dut0.
  logic [15:0] m_tbl [2];
  bit          m_busy;
  bit          m_done;
  int          m_ch;
  int          m_nb;
  logic [15:0] m_sh;
  bit          m_ov;
  logic [1:0]  m_od;
  int          m_cnt [2];

  logic [15:0] init_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tbl[0] = 16'hE677;
    m_tbl[1] = 16'hE677;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ch = 0;
    m_nb = 0;
    m_sh = 16'h0000;
    m_ov = 1'b0;
    m_od = 2'b00;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // One clock of dut0 with the currently applied inputs, checked against the model.
  task automatic cyc();
    bit         rdy, acc, xfr, r, st, bv, b;
    int         ch;
    logic [3:0] din;
    #1;
    rdy = !m_busy && (!m_ov || bus0.out_ready);
    check("in_ready", {63'd0, bus0.in_ready}, {63'd0, rdy});
    acc = bus0.in_valid && rdy;
    xfr = m_ov && bus0.out_ready;
    r   = rst;
    st  = bus0.cfg_start;
    ch  = int'(bus0.cfg_ch);
    bv  = bus0.cfg_bit_valid;
    b   = bus0.cfg_bit;
    din = bus0.in_data;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (xfr) begin
        for (int c = 0; c < 2; c++) begin
          if (m_od[c]) m_cnt[c] = (m_cnt[c] + 1 > 255) ? 255 : m_cnt[c] + 1;
        end
      end
      if (acc) begin
        for (int c = 0; c < 2; c++) m_od[c] = m_tbl[c][din];
        m_ov = 1'b1;
      end else if (xfr) begin
        m_ov = 1'b0;
      end
      m_done = 1'b0;
      if (!m_busy) begin
        if (st) begin
          m_busy = 1'b1;
          m_ch = ch;
          m_sh = 16'h0000;
          m_nb = 0;
        end
      end else if (bv) begin
        m_sh = (m_sh << 1) | {15'd0, b};
        m_nb++;
        if (m_nb == 16) begin
          if (m_ch < 2) m_tbl[m_ch] = m_sh;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    check("out_valid", {63'd0, bus0.out_valid}, {63'd0, m_ov});
    check("out_data", {62'd0, bus0.out_data}, {62'd0, m_od});
    check("cfg_busy", {63'd0, bus0.cfg_busy}, {63'd0, m_busy});
    check("cfg_done", {63'd0, bus0.cfg_done}, {63'd0, m_done});
    check("ones_cnt", {48'd0, bus0.ones_cnt}, {48'd0, 8'(m_cnt[1]), 8'(m_cnt[0])});
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] idx_list [4];
    logic [1:0] exp_list [4];
    int         guard;
    init_c = 16'hE677;
    idx_list = '{4'd0, 4'd3, 4'd8, 4'd15};
    exp_list = '{2'b11, 2'b00, 2'b00, 2'b11};

    rst = 1'b1;
    bus0.cfg_start = 1'b0; bus0.cfg_ch = 1'b0; bus0.cfg_bit_valid = 1'b0; bus0.cfg_bit = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = 4'd0; bus0.out_ready = 1'b0;
    bus1.cfg_start = 1'b0; bus1.cfg_ch = 1'b0; bus1.cfg_bit_valid = 1'b0; bus1.cfg_bit = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 4'd0; bus1.out_ready = 1'b0;
    model_reset();
    m_busy = 1'b0;

    // Reset defaults.
    edge1();
    edge1();
    cyc();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
    check("rst_ones_cnt", {48'd0, bus0.ones_cnt}, 64'd0);
    #1;
    check("rst_in_ready", {63'd0, bus0.in_ready}, 64'd1);

    // INIT lookups.
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data = idx_list[i];
      cyc();
      check("init_lookup", {62'd0, bus0.out_data}, {62'd0, exp_list[i]});
    end
    bus0.in_valid = 1'b0;

    // Load channel 0 with 16'h0001.
    bus0.cfg_start = 1'b1;
    bus0.cfg_ch = 1'b0;
    cyc();
    bus0.cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus0.cfg_bit_valid = 1'b1;
      bus0.cfg_bit = (i == 15);
      cyc();
    end
    check("load_done", {63'd0, bus0.cfg_done}, 64'd1);
    bus0.cfg_bit_valid = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data = 4'd0;
    cyc();
    check("load_idx0", {62'd0, bus0.out_data}, 64'd3);
    bus0.in_data = 4'd9;
    cyc();
    check("load_idx9", {62'd0, bus0.out_data}, 64'd2);

    // Backpressure then release.
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.in_data = 4'($urandom_range(0, 15));
      cyc();
    end
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.in_data = 4'($urandom_range(0, 15));
      cyc();
    end

    // Randomised traffic with random loads and bit gaps.
    for (int k = 0; k < 300; k++) begin
      bus0.in_valid = ($urandom_range(0, 3) != 0);
      bus0.in_data = 4'($urandom_range(0, 15));
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      bus0.cfg_start = ($urandom_range(0, 24) == 0);
      bus0.cfg_ch = 1'($urandom_range(0, 1));
      bus0.cfg_bit_valid = ($urandom_range(0, 1) == 1);
      bus0.cfg_bit = 1'($urandom_range(0, 1));
      cyc();
    end

    // Finish any open load.
    bus0.cfg_start = 1'b0;
    bus0.cfg_bit_valid = 1'b1;
    guard = 0;
    while (m_busy && guard < 20) begin
      cyc();
      guard++;
    end
    check("drain_idle", {63'd0, bus0.cfg_busy}, 64'd0);

    // Interrupted load: 7 bits with gaps, then reset.
    bus0.cfg_bit_valid = 1'b0;
    bus0.cfg_start = 1'b1;
    bus0.cfg_ch = 1'b1;
    cyc();
    bus0.cfg_start = 1'b0;
    guard = 0;
    while (m_nb < 7 && guard < 60) begin
      bus0.cfg_bit_valid = ($urandom_range(0, 1) == 1);
      bus0.cfg_bit = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.out_ready = 1'b1;
      cyc();
      #1;
      check("load_in_ready", {63'd0, bus0.in_ready}, 64'd0);
      guard++;
    end
    check("seven_bits", 64'(m_nb), 64'd7);
    bus0.cfg_bit_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_busy", {63'd0, bus0.cfg_busy}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data = 4'(i);
      cyc();
      check("init_readback", {62'd0, bus0.out_data}, {62'd0, init_c[i], init_c[i]});
    end
    bus0.in_valid = 1'b0;

    // dut1: counter saturation at 3.
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data = 4'd0;
    bus1.out_ready = 1'b1;
    repeat (3) edge1();
    check("sat_mid", {62'd0, bus1.ones_cnt}, 64'd2);
    repeat (5) edge1();
    check("sat_cnt", {62'd0, bus1.ones_cnt}, 64'd3);
    check("sat_data", {63'd0, bus1.out_data}, 64'd1);
    edge1();
    check("sat_hold", {62'd0, bus1.ones_cnt}, 64'd3);

    // dut1: out-of-range channel load is discarded but still completes.
    bus1.in_valid = 1'b0;
    bus1.cfg_start = 1'b1;
    bus1.cfg_ch = 1'b1;
    edge1();
    bus1.cfg_start = 1'b0;
    check("oor_busy", {63'd0, bus1.cfg_busy}, 64'd1);
    bus1.cfg_bit_valid = 1'b1;
    bus1.cfg_bit = 1'b0;
    repeat (15) edge1();
    check("oor_not_done", {63'd0, bus1.cfg_done}, 64'd0);
    edge1();
    check("oor_done", {63'd0, bus1.cfg_done}, 64'd1);
    check("oor_idle", {63'd0, bus1.cfg_busy}, 64'd0);
    bus1.cfg_bit_valid = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data = 4'd0;
    edge1();
    check("oor_done_pulse", {63'd0, bus1.cfg_done}, 64'd0);
    check("oor_idx0", {63'd0, bus1.out_data}, 64'd1);
    bus1.in_data = 4'd3;
    edge1();
    check("oor_idx3", {63'd0, bus1.out_data}, 64'd0);
    bus1.in_data = 4'd15;
    edge1();
    check("oor_idx15", {63'd0, bus1.out_data}, 64'd1);
    bus1.in_valid = 1'b0;
    edge1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tt_lut_cell.md
# tt_lut_cell

Programmable multi-channel truth-table evaluation cell. It is the registered, reconfigurable successor to the fixed 4-input NOR/NOT truth-table gates the flow generates. Each of `N_CH` channels holds a `2^N_IN`-bit truth table that can be reloaded at run time through a serial configuration port, with atomic commit. Input vectors are evaluated against all channels in parallel behind a valid/ready pipeline stage, and a saturating per-channel count of emitted ones is kept.

## Interface
- `N_IN`, default 4: number of logic inputs; table depth `T = 2^N_IN`.
- `N_CH`, default 2: number of independent channels (tables).
- `INIT`, default `{N_CH{16'hE677}}`: reset table contents; channel c occupies bits `[c*T +: T]`.
- `CNT_W`, default 8: width of each per-channel ones counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_start`, in, 1: begin a serial table load (honoured only in IDLE).
- `cfg_ch`, in, `clog2(N_CH)` (min 1): target channel, sampled with `cfg_start`.
- `cfg_bit_valid`, in, 1: `cfg_bit` is valid this cycle.
- `cfg_bit`, in, 1: serial table bit, MSB (index `T-1`) first.
- `cfg_busy`, out, 1: high while in LOAD.
- `cfg_done`, out, 1: one-cycle pulse on commit.
- `in_valid`, in, 1: input vector valid.
- `in_ready`, out, 1: cell accepts input.
- `in_data`, in, `N_IN`: table index.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts result.
- `out_data`, out, `N_CH`: bit c = `table_c[in_data]`.
- `ones_cnt`, out, `N_CH*CNT_W`: per-channel saturating count of transferred ones.

## Operation
- **Config FSM**
  - IDLE: `cfg_start` latches `cfg_ch`, clears the shadow register and the bit counter, then goes to LOAD.
  - LOAD: each `cfg_bit_valid` shifts `cfg_bit` into the LSB of the shadow register (shift left) and increments the bit counter. Cycles without `cfg_bit_valid` stall with no timeout.
  - On the T-th valid bit, the shadow register is copied into the target table at that clock edge and the FSM returns to IDLE.
  - `cfg_start` in LOAD is ignored. `cfg_ch >= N_CH` is loaded and then discarded, with no table change but `cfg_done` still pulsing.
- **Atomic commit**: a partially loaded table is never visible. Results always use either the complete old table or the complete new one.
- **Evaluate**
  - `in_ready = !cfg_busy && (!out_valid || out_ready)`.
  - When `in_valid && in_ready`: `out_data` is registered from the current tables and `out_valid` is set.
  - When `out_valid && out_ready` and no new accept occurs, `out_valid` clears.
  - `out_data` holds stable while `out_valid && !out_ready`.
- **Counters**: on each output transfer (`out_valid && out_ready`), every channel with `out_data[c] = 1` increments `ones_cnt[c]`. Counters saturate at `2^CNT_W - 1`.
- **Reset**
  - tables = `INIT`
  - FSM = IDLE
  - `cfg_busy = 0`, `cfg_done = 0`
  - `out_valid = 0`, `out_data = 0`
  - `ones_cnt = 0`
  - `in_ready = 1` in the first cycle after reset.
  - Reset during LOAD discards the shadow register; the target table stays `INIT`.

## Timing
- Evaluation latency is 1 cycle: data accepted at edge k gives `out_valid` high after edge k.
- Full throughput is 1 vector per cycle while `out_ready = 1`.
- `cfg_busy` rises the cycle after `cfg_start` is accepted.
- On the edge that takes the T-th bit: the table updates, `cfg_busy` falls, and `cfg_done` pulses for one cycle. `in_ready` may rise in that same cycle.
- A minimum load takes T+1 cycles, from `cfg_start` to `cfg_done`.
- An output already held in the register across a load is unaffected by the commit.
- `in_ready` stays low for the whole LOAD even if `out_ready = 1`.
- Counter updates are visible one cycle after the transfer edge.

## Test plan
- Reset defaults, `INIT = E677` on both channels: apply `in_data` 0, 3, 8, 15 with `out_ready = 1` → `out_data` = 2'b11, 2'b00, 2'b00, 2'b11, each 1 cycle after accept.
- Load channel 0 with 16'h0001 by sending 15 zero bits then a single one → `cfg_done` pulses after the 16th bit. Then `in_data = 0` gives `out_data = 2'b11` and `in_data = 9` gives `2'b10`.
- Backpressure: hold `out_ready = 0` with `in_valid` high → a single accept, `in_ready` low, `out_data` stable. Release `out_ready` → back-to-back results, none dropped or duplicated.
- Gaps and interruption: load with random `cfg_bit_valid` gaps; during LOAD `in_ready = 0`. Assert `rst` after 7 bits → the table reads back as `INIT`, `cfg_busy = 0`.
- Counter saturation: with `CNT_W = 2`, drive 6 transfers of `in_data = 0` → `ones_cnt` = 3 on both channels and holds.
- Out-of-range `cfg_ch = 1` with `N_CH = 1`: complete the load → `cfg_done` pulses and channel 0 is unchanged.
